// File: rtl/ucode_sequencer_if.sv
// Signal bundle between the micro-program sequencer, its control memory and the
// downstream decoder. The sequencer takes the slave view, its environment the master view.
interface ucode_sequencer_if #(
  parameter int unsigned UPC_W = 6,
  parameter int unsigned CW_W  = 16
) ();
  logic                  start;
  logic [UPC_W-1:0]      start_addr;
  logic                  abort;
  logic                  hold;
  logic                  cm_en;
  logic [UPC_W-1:0]      cm_addr;
  logic [CW_W-1:0]       cm_rdata;
  logic                  dec_call;
  logic                  dec_en;
  logic [CW_W-UPC_W-4:0] uops;
  logic                  busy;
  logic                  done;
  logic                  fault;

  modport slave (
    input  start, start_addr, abort, hold, cm_rdata,
    output cm_en, cm_addr, dec_call, dec_en, uops, busy, done, fault
  );

  modport master (
    output start, start_addr, abort, hold, cm_rdata,
    input  cm_en, cm_addr, dec_call, dec_en, uops, busy, done, fault
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Micro-program sequencer: holds the micro-PC, fetches control words from a synchronous
// ROM and resolves SEQ/JMP/CALL/RET with a small return stack ahead of the op-type decoder.
module ucode_sequencer #(
  parameter int unsigned UPC_W       = 6,
  parameter int unsigned CW_W        = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  ucode_sequencer_if.slave bus
);
  localparam int unsigned UOP_W    = CW_W - UPC_W - 3;
  localparam int unsigned SP_W     = $clog2(STACK_DEPTH + 1);
  localparam int unsigned TYPE_BIT = CW_W - 3 - UPC_W;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_FAULT} state_e;
  typedef enum logic [1:0] {OP_SEQ = 2'b00, OP_JMP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11} op_e;

  state_e           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic             done_q, done_d;
  logic             push;
  logic [UPC_W-1:0] stack_q [STACK_DEPTH];
  logic [UPC_W-1:0] upc_inc;
  logic [UPC_W-1:0] ret_addr;
  logic [UPC_W-1:0] target;
  op_e              op;
  logic             issuing;

  assign op      = op_e'(cw_q[CW_W-1 -: 2]);
  assign target  = cw_q[CW_W-3 -: UPC_W];
  assign upc_inc = upc_q + UPC_W'(1);
  assign issuing = (state_q == S_ISSUE);

  // Top-of-stack select; entry sp-1 holds the most recent return address.
  always_comb begin
    ret_addr = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) ret_addr = stack_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    sp_d    = sp_q;
    cw_d    = cw_q;
    done_d  = 1'b0;
    push    = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      sp_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            upc_d   = bus.start_addr;
            sp_d    = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          cw_d    = bus.cm_rdata;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          if (!bus.hold) begin
            state_d = S_FETCH;
            unique case (op)
              OP_SEQ: upc_d = upc_inc;
              OP_JMP: upc_d = target;
              OP_CALL: begin
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                  state_d = S_FAULT;
                end else begin
                  push  = 1'b1;
                  sp_d  = sp_q + SP_W'(1);
                  upc_d = target;
                end
              end
              OP_RET: begin
                if (sp_q == '0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end else begin
                  sp_d  = sp_q - SP_W'(1);
                  upc_d = ret_addr;
                end
              end
            endcase
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      sp_q    <= '0;
      cw_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      sp_q    <= sp_d;
      cw_q    <= cw_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        if (sp_q == SP_W'(i)) stack_q[i] <= upc_inc;
      end
    end
  end

  assign bus.cm_en    = (state_q == S_FETCH);
  assign bus.cm_addr  = upc_q;
  assign bus.dec_en   = issuing;
  assign bus.dec_call = issuing & cw_q[TYPE_BIT];
  assign bus.uops     = issuing ? cw_q[UOP_W-1:0] : '0;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.fault    = (state_q == S_FAULT);
endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed programs plus random ROM images, checked cycle by
// cycle against an instruction-level interpreter of the control-word rules.
module tb_ucode_sequencer;
  localparam int OUT_DONE  = 0;
  localparam int OUT_FAULT = 1;
  localparam int OUT_TRUNC = 2;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [5:0] addr;
    logic       typ;
    logic [6:0] uops;
  } iss_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] rom [64];
  iss_t        exp_q [$];
  int          exp_outcome;
  int          n_cmp = 0;
  int          n_fail = 0;

  ucode_sequencer_if #(.UPC_W(6), .CW_W(16)) bus ();

  ucode_sequencer #(.UPC_W(6), .CW_W(16), .STACK_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data valid only the cycle after cm_en, garbage otherwise.
  always @(posedge clk) begin
    if (bus.cm_en) bus.cm_rdata <= rom[bus.cm_addr];
    else           bus.cm_rdata <= 16'($urandom);
  end

  task automatic fill_rom(input logic [15:0] w);
    for (int a = 0; a < 64; a++) rom[a] = w;
  endtask

  // Instruction-level interpreter: list of issued words and how the program ends.
  task automatic model(input logic [5:0] saddr, input int unsigned limit);
    logic [5:0]  pc;
    logic [5:0]  nxt;
    logic [15:0] w;
    logic [5:0]  stk [$];
    pc = saddr;
    exp_q.delete();
    exp_outcome = OUT_TRUNC;
    for (int unsigned k = 0; k < limit; k++) begin
      w = rom[pc];
      exp_q.push_back('{pc, w[7], w[6:0]});
      nxt = pc + 6'd1;
      case (w[15:14])
        2'b00: pc = nxt;
        2'b01: pc = w[13:8];
        2'b10: begin
          if (stk.size() == DEPTH) begin
            exp_outcome = OUT_FAULT;
            return;
          end
          stk.push_back(nxt);
          pc = w[13:8];
        end
        default: begin
          if (stk.size() == 0) begin
            exp_outcome = OUT_DONE;
            return;
          end
          pc = stk.pop_back();
        end
      endcase
    end
  endtask

  // Launch a program at the current negedge and follow it to its end.
  task automatic run_prog(input string name, input logic [5:0] saddr, input int unsigned hold_pct,
                          input int unsigned first_hold, input int unsigned limit, input bit chain);
    int unsigned idx = 0;
    int unsigned ph = 0;
    int unsigned held = 0;
    int unsigned cyc = 0;
    bit fin = 0;
    bit h;
    model(saddr, limit);
    bus.start_addr = saddr;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!fin) begin
      cyc++;
      if (cyc > 3000) begin
        n_cmp++; n_fail++;
        $display("FAIL %s timeout: no completion after %0d cycles", name, cyc);
        break;
      end
      case (ph)
        0: begin
          n_cmp++;
          if ({bus.cm_en, bus.dec_en, bus.busy, bus.done, bus.cm_addr} !==
              {1'b1, 1'b0, 1'b1, 1'b0, exp_q[idx].addr}) begin
            n_fail++;
            $display("FAIL %s fetch #%0d: {cm_en,dec_en,busy,done,addr}=%b_%b_%b_%b_%h expected 1_0_1_0_%h",
                     name, idx, bus.cm_en, bus.dec_en, bus.busy, bus.done, bus.cm_addr, exp_q[idx].addr);
          end
          ph = 1;
        end
        1: begin
          n_cmp++;
          if ({bus.cm_en, bus.dec_en, bus.busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s load #%0d: {cm_en,dec_en,busy}=%b%b%b expected 001",
                     name, idx, bus.cm_en, bus.dec_en, bus.busy);
          end
          ph = 2;
        end
        default: begin
          n_cmp++;
          if ({bus.cm_en, bus.dec_en, bus.busy, bus.dec_call, bus.uops, bus.cm_addr} !==
              {1'b0, 1'b1, 1'b1, exp_q[idx].typ, exp_q[idx].uops, exp_q[idx].addr}) begin
            n_fail++;
            $display("FAIL %s issue #%0d: en=%b dec_en=%b busy=%b call=%b uops=%h addr=%h expected 0 1 1 %b %h %h",
                     name, idx, bus.cm_en, bus.dec_en, bus.busy, bus.dec_call, bus.uops, bus.cm_addr,
                     exp_q[idx].typ, exp_q[idx].uops, exp_q[idx].addr);
          end
          if (exp_outcome == OUT_TRUNC && idx == exp_q.size() - 1) begin
            bus.abort = 1'b1;
            bus.hold  = 1'b1;
            fin = 1;
          end else begin
            h = (idx == 0 && held < first_hold) || ($urandom_range(99) < hold_pct);
            bus.hold = h;
            if (h) begin
              held++;
            end else begin
              idx++;
              ph = 0;
              if (idx == exp_q.size()) fin = 1;
            end
          end
        end
      endcase
      @(negedge clk);
    end
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    if (exp_outcome == OUT_DONE) begin
      n_cmp++;
      if ({bus.done, bus.busy, bus.dec_en, bus.cm_en, bus.fault} !== 5'b10000) begin
        n_fail++;
        $display("FAIL %s done_pulse: {done,busy,dec_en,cm_en,fault}=%b%b%b%b%b expected 10000",
                 name, bus.done, bus.busy, bus.dec_en, bus.cm_en, bus.fault);
      end
      if (!chain) begin
        @(negedge clk);
        n_cmp++;
        if ({bus.done, bus.busy} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s after_done: {done,busy}=%b%b expected 00", name, bus.done, bus.busy);
        end
      end
    end else if (exp_outcome == OUT_FAULT) begin
      bus.start = 1'b1;
      bus.start_addr = 6'h01;
      repeat (3) begin
        n_cmp++;
        if ({bus.fault, bus.busy, bus.dec_en, bus.cm_en, bus.done} !== 5'b11000) begin
          n_fail++;
          $display("FAIL %s fault_state: {fault,busy,dec_en,cm_en,done}=%b%b%b%b%b expected 11000",
                   name, bus.fault, bus.busy, bus.dec_en, bus.cm_en, bus.done);
        end
        @(negedge clk);
      end
      bus.start = 1'b0;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      n_cmp++;
      if ({bus.fault, bus.busy, bus.done, bus.dec_en} !== 4'b0000) begin
        n_fail++;
        $display("FAIL %s fault_abort: {fault,busy,done,dec_en}=%b%b%b%b expected 0000",
                 name, bus.fault, bus.busy, bus.done, bus.dec_en);
      end
    end else begin
      repeat (2) begin
        n_cmp++;
        if ({bus.busy, bus.done, bus.dec_en, bus.fault, bus.cm_en} !== 5'b00000) begin
          n_fail++;
          $display("FAIL %s abort_idle: {busy,done,dec_en,fault,cm_en}=%b%b%b%b%b expected 00000",
                   name, bus.busy, bus.done, bus.dec_en, bus.fault, bus.cm_en);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.cm_en, bus.cm_addr, bus.dec_call, bus.dec_en, bus.uops, bus.busy, bus.done, bus.fault} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {bus.cm_en, bus.cm_addr, bus.dec_call, bus.dec_en, bus.uops, bus.busy, bus.done, bus.fault});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.cm_en, bus.dec_en, bus.done, bus.fault} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_idle: {busy,cm_en,dec_en,done,fault}=%b%b%b%b%b expected 00000",
               bus.busy, bus.cm_en, bus.dec_en, bus.done, bus.fault);
    end
  endtask

  task automatic test_linear();
    fill_rom(16'hC000);
    rom[5] = 16'h0091;
    rom[6] = 16'hC000;
    run_prog("linear", 6'd5, 0, 0, 64, 0);
  endtask

  task automatic test_call_ret();
    fill_rom(16'hC000);
    rom[0]    = 16'hA000;
    rom[6'h20] = 16'hC000;
    rom[1]    = 16'hC000;
    run_prog("call_ret", 6'd0, 0, 0, 64, 0);
  endtask

  task automatic test_overflow();
    fill_rom(16'hC000);
    rom[6'h10] = 16'h9000;
    run_prog("overflow", 6'h10, 0, 0, 64, 0);
  endtask

  task automatic test_hold();
    fill_rom(16'hC000);
    rom[3] = 16'h00DA;
    rom[4] = 16'hC000;
    run_prog("hold", 6'd3, 0, 4, 64, 0);
  endtask

  task automatic test_wrap_abort();
    fill_rom(16'hC000);
    rom[63] = 16'h0000;
    run_prog("wrap", 6'd63, 0, 0, 64, 0);
    rom[63] = 16'h8000;
    rom[0]  = 16'h7F00;
    run_prog("abort_hold", 6'd63, 0, 0, 4, 0);
    bus.start = 1'b1;
    bus.start_addr = 6'h3E;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.cm_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_beats_start: {busy,cm_en}=%b%b expected 00", bus.busy, bus.cm_en);
    end
    run_prog("sp_cleared", 6'h3E, 0, 0, 64, 0);
  endtask

  task automatic test_back_to_back();
    fill_rom(16'hC000);
    rom[5] = 16'h0091;
    rom[6] = 16'hC000;
    run_prog("b2b_first", 6'd5, 0, 0, 64, 1);
    run_prog("b2b_second", 6'd5, 20, 0, 64, 0);
  endtask

  task automatic test_reset_mid();
    fill_rom(16'hC000);
    rom[6'h2A] = 16'h0000;
    rom[5] = 16'h0091;
    rom[6] = 16'hC000;
    bus.start_addr = 6'h2A;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.cm_en, bus.cm_addr} !== {1'b1, 1'b0, 6'h2A}) begin
      n_fail++;
      $display("FAIL reset_mid_load: {busy,cm_en,addr}=%b%b%h expected 1_0_2a", bus.busy, bus.cm_en, bus.cm_addr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.cm_en, bus.cm_addr, bus.dec_call, bus.dec_en, bus.uops, bus.busy, bus.done, bus.fault} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected 0",
               {bus.cm_en, bus.cm_addr, bus.dec_call, bus.dec_en, bus.uops, bus.busy, bus.done, bus.fault});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_prog("after_reset", 6'd5, 0, 0, 64, 0);
  endtask

  task automatic test_random();
    int unsigned r;
    logic [15:0] w;
    for (int t = 0; t < 12; t++) begin
      for (int a = 0; a < 64; a++) begin
        r = $urandom_range(99);
        w = 16'($urandom);
        w[15:14] = (r < 45) ? 2'b00 : (r < 55) ? 2'b01 : (r < 75) ? 2'b10 : 2'b11;
        rom[a] = w;
      end
      run_prog("random", 6'($urandom), $urandom_range(40), 0, 40, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.abort = 1'b0;
    bus.hold = 1'b0;
    fill_rom(16'hC000);
    test_reset();
    test_linear();
    test_call_ret();
    test_overflow();
    test_hold();
    test_wrap_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Micro-program sequencer for the CtrlPIM control unit. It sits directly upstream of the 1-to-2 uCode operation-type decoder.
- Holds the micro-PC and fetches control words from a synchronous control-memory ROM. It resolves sequencing ops SEQ, JMP, CALL and RET using a small return stack.
- For each fetched word it presents the operation-type select bit (dec_call) and the decoder enable (dec_en), plus the micro-op field, to downstream stages.

Parameters:
- UPC_W, 6, micro-PC / control-memory address width.
- CW_W, 16, control-word width; must be at least UPC_W+4.
- STACK_DEPTH, 4, return-stack entries (1..8).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch a micro-program; sampled only in IDLE.
- start_addr  in  UPC_W  entry address of the micro-program.
- abort  in  1  force return to IDLE from any state.
- hold  in  1  downstream stall; retire of the current word is blocked while high.
- cm_en  out  1  control-memory read enable.
- cm_addr  out  UPC_W  control-memory address (= upc).
- cm_rdata  in  CW_W  control-memory data; valid the cycle after cm_en.
- dec_call  out  1  operation-type select bit to the decoder.
- dec_en  out  1  decoder enable.
- uops  out  CW_W-UPC_W-3  micro-op field.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse on normal completion.
- fault  out  1  sticky stack fault (overflow).

Behaviour:
- Control-word fields, defaults in brackets:
  - op = cw[CW_W-1:CW_W-2] [15:14]; 00 SEQ, 01 JMP, 10 CALL, 11 RET.
  - target = cw[CW_W-3 -: UPC_W] [13:8].
  - type = cw[CW_W-3-UPC_W] [7].
  - uops = cw[CW_W-4-UPC_W:0] [6:0].
- States: IDLE, FETCH, LOAD, ISSUE, FAULT. Reset values: state IDLE, upc 0, sp 0, cw_q 0. All outputs are 0 at reset; cm_addr = 0.
- All outputs decode from registered state only; there is no combinational path from any input to any output.
- IDLE: when start=1, load upc<=start_addr and sp<=0, then go to FETCH.
- FETCH: cm_en=1 for exactly this cycle; next state LOAD.
- LOAD: capture cw_q<=cm_rdata; next state ISSUE.
- ISSUE:
  - dec_en=1, dec_call=cw_q.type, uops=cw_q.uops.
  - While hold=1: stay in ISSUE with all outputs stable.
  - When hold=0, retire the word according to op:
    - SEQ: upc<=upc+1, wrapping modulo 2^UPC_W; go to FETCH.
    - JMP: upc<=target; go to FETCH.
    - CALL with sp<STACK_DEPTH: stack[sp]<=upc+1 (wrapped), sp<=sp+1, upc<=target; go to FETCH.
    - CALL with sp==STACK_DEPTH: go to FAULT; upc and sp are unchanged.
    - RET with sp>0: sp<=sp-1, upc<=stack[sp-1]; go to FETCH.
    - RET with sp==0: end of program; done=1 in the following cycle; go to IDLE.
- done asserts during the first IDLE cycle after completion. A start in that same cycle is accepted.
- FAULT: fault=1, busy=1, dec_en=0. The block leaves FAULT only via abort or reset; start is ignored.
- abort=1 in any state: next state IDLE, sp<=0, fault cleared, no done pulse. If abort and start arrive together in IDLE, abort wins and start is ignored.
- Timing: each microinstruction takes 3 cycles (FETCH, LOAD, ISSUE) plus any hold cycles. From start to the first dec_en is 3 cycles.
- An op retires exactly once per ISSUE visit, regardless of how long hold stays high.
- Asynchronous reset mid-program returns all state and outputs immediately to the reset values.

Test Plan:
- Linear program: ROM[5]=SEQ type=1 uops=0x11; ROM[6]=RET type=0.
  - Pulse start with start_addr=5.
  - Required: cm_addr 5 then 6; dec_en high in cycles 3 and 6; dec_call 1 then 0; done pulses in cycle 7; busy low afterwards.
- Call/return: ROM[0]=CALL target 0x20; ROM[0x20]=RET; ROM[1]=RET.
  - Required fetch sequence 0, 0x20, 1; sp goes 1 then 0; done pulses once.
- Overflow: ROM[0x10]=CALL target 0x10 with STACK_DEPTH=4.
  - Required: four successful pushes, then fault=1 after the fifth ISSUE; dec_en stays 0 afterwards; abort clears fault and returns busy to 0.
- Hold: hold=1 for 4 cycles during ISSUE of a SEQ at upc=3.
  - Required: dec_en, dec_call and uops are stable for 5 cycles; exactly one increment to upc=4.
- Wrap and abort: SEQ at upc=63 must fetch address 0 next.
  - Assert abort together with hold in ISSUE: required IDLE next cycle, sp=0, no done pulse.
- Reset mid-program: drop rst_n low during LOAD.
  - Required: all outputs 0 immediately (asynchronously); a start after rst_n rises behaves as from cold reset.
